// File: rtl/spi_peripheral_mem_if.sv
// rtl/spi_peripheral_mem_if.sv - serial frame bus between SPI controller and memory target
interface spi_peripheral_mem_if;
    logic cs;
    logic mosi;
    logic miso;
    logic ready;
    logic op_done;
    logic err;

    modport master (
        output cs,
        output mosi,
        input  miso,
        input  ready,
        input  op_done,
        input  err
    );

    modport slave (
        input  cs,
        input  mosi,
        output miso,
        output ready,
        output op_done,
        output err
    );
endinterface

// File: rtl/spi_peripheral_mem.sv
// rtl/spi_peripheral_mem.sv - SPI-style target fronting a DEPTH x 8 register file
module spi_peripheral_mem #(
    parameter int DEPTH    = 32,
    parameter int READ_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    spi_peripheral_mem_if.slave      bus,
    input  logic [$clog2(DEPTH)-1:0] dbg_addr,
    output logic [7:0]               dbg_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_WAIT_CS,
        S_WRITE,
        S_RD_WAIT,
        S_RDY,
        S_TX
    } state_t;

    state_t         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [16:0]    sr_q, sr_d;
    logic [LW-1:0]  lat_q, lat_d;
    logic           seen_q, seen_d;
    logic [3:0]     tx_cnt_q, tx_cnt_d;
    logic [7:0]     rdata_q, rdata_d;
    logic           miso_q, miso_d;
    logic           ready_q, ready_d;
    logic           op_done_q, op_done_d;
    logic           err_q, err_d;
    logic           mem_we;
    logic [7:0]     mem_q [DEPTH];

    // Frame fields: bit0 = wr, bits 1..8 = addr, bits 9..16 = data
    logic           frm_wr;
    logic [7:0]     frm_addr;
    logic [7:0]     frm_data;
    logic           addr_ok;
    logic [AW-1:0]  mem_idx;
    logic           rd_go;

    assign frm_wr   = sr_q[0];
    assign frm_addr = sr_q[8:1];
    assign frm_data = sr_q[16:9];
    // Full 8-bit compare so out-of-range addresses never alias into the array
    assign addr_ok  = ({24'd0, frm_addr} < DEPTH);
    assign mem_idx  = frm_addr[AW-1:0];

    // Read latency: count starts on the first edge that sees cs high
    assign rd_go = seen_q ? (lat_q == LW'(READ_LAT)) : (bus.cs && (READ_LAT == 0));

    assign bus.miso    = miso_q;
    assign bus.ready   = ready_q;
    assign bus.op_done = op_done_q;
    assign bus.err     = err_q;

    assign dbg_data = ({{(32-AW){1'b0}}, dbg_addr} < DEPTH) ? mem_q[dbg_addr] : 8'h00;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (!bus.cs) state_d = S_RX;
            S_RX: begin
                if (bus.cs) begin
                    state_d = S_IDLE;
                end else if (!frm_wr && cnt_q == 5'd8) begin
                    state_d = S_RD_WAIT;
                end else if (frm_wr && cnt_q == 5'd16) begin
                    state_d = S_WAIT_CS;
                end
            end
            S_WAIT_CS: if (bus.cs) state_d = S_WRITE;
            S_WRITE:   state_d = S_IDLE;
            S_RD_WAIT: if (rd_go) state_d = S_RDY;
            S_RDY:     state_d = S_TX;
            S_TX:      if (tx_cnt_q == 4'd8) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values per state
    always_comb begin
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        lat_d     = lat_q;
        seen_d    = seen_q;
        tx_cnt_d  = tx_cnt_q;
        rdata_d   = rdata_q;
        miso_d    = 1'b0;
        ready_d   = 1'b0;
        op_done_d = 1'b0;
        err_d     = err_q;
        mem_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!bus.cs) begin
                    sr_d   = {16'd0, bus.mosi};
                    cnt_d  = 5'd1;
                    seen_d = 1'b0;
                    lat_d  = '0;
                end
            end
            S_RX: begin
                if (!bus.cs) begin
                    sr_d[cnt_q] = bus.mosi;
                    cnt_d       = cnt_q + 5'd1;
                end else begin
                    cnt_d = 5'd0;
                end
            end
            S_WRITE: begin
                mem_we    = addr_ok;
                err_d     = !addr_ok;
                op_done_d = 1'b1;
            end
            S_RD_WAIT: begin
                if (rd_go) begin
                    rdata_d = addr_ok ? mem_q[mem_idx] : 8'h00;
                    err_d   = !addr_ok;
                    ready_d = 1'b1;
                end else if (seen_q) begin
                    lat_d = lat_q + LW'(1);
                end else if (bus.cs) begin
                    seen_d = 1'b1;
                    lat_d  = LW'(1);
                end
            end
            S_RDY: begin
                miso_d   = rdata_q[0];
                tx_cnt_d = 4'd1;
            end
            S_TX: begin
                if (tx_cnt_q != 4'd8) begin
                    miso_d   = rdata_q[tx_cnt_q[2:0]];
                    tx_cnt_d = tx_cnt_q + 4'd1;
                end
            end
            default: begin
                cnt_d = 5'd0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 5'd0;
            sr_q      <= 17'd0;
            lat_q     <= '0;
            seen_q    <= 1'b0;
            tx_cnt_q  <= 4'd0;
            rdata_q   <= 8'h00;
            miso_q    <= 1'b0;
            ready_q   <= 1'b0;
            op_done_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            lat_q     <= lat_d;
            seen_q    <= seen_d;
            tx_cnt_q  <= tx_cnt_d;
            rdata_q   <= rdata_d;
            miso_q    <= miso_d;
            ready_q   <= ready_d;
            op_done_q <= op_done_d;
            err_q     <= err_d;
        end
    end

    // Storage array; contents survive reset, but a reset in WRITE blocks the commit
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[mem_idx] <= frm_data;
        end
    end

endmodule

// File: tb/tb_spi_peripheral_mem.sv
// tb/tb_spi_peripheral_mem.sv - self-checking bench for spi_peripheral_mem
module tb_spi_peripheral_mem;

    localparam int DEPTH    = 32;
    localparam int READ_LAT = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] dbg_addr = 5'd0;
    logic [7:0] dbg_data;

    spi_peripheral_mem_if bus();

    spi_peripheral_mem #(.DEPTH(DEPTH), .READ_LAT(READ_LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         passes = 0;
    logic [7:0] ref_mem [DEPTH];
    logic       ref_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [16:0] frame, input int n);
        bus.cs = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.mosi = frame[i];
            tick();
        end
        bus.cs   = 1'b1;
        bus.mosi = 1'b0;
    endtask

    task automatic wait_pulse(input bit want_ready, output int lat);
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (want_ready ? bus.ready : bus.op_done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic scan_mem(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            dbg_addr = 5'(i);
            #1;
            check($sformatf("%s mem[%0d]", tag, i), dbg_data, ref_mem[i]);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input string tag);
        int   lat;
        logic ok;
        ok = ({24'd0, a} < DEPTH);
        send_bits({d, a, 1'b1}, 17);
        wait_pulse(1'b0, lat);
        check({tag, " op_done latency"}, lat, 2);
        check({tag, " ready low at op_done"}, bus.ready, 1'b0);
        if (ok) ref_mem[a[4:0]] = d;
        ref_err = !ok;
        check({tag, " err"}, bus.err, ref_err);
        tick();
        check({tag, " op_done one cycle"}, bus.op_done, 1'b0);
        if (ok) begin
            dbg_addr = a[4:0];
            #1;
            check({tag, " dbg_data"}, dbg_data, d);
        end
    endtask

    task automatic do_read(input logic [7:0] a, input string tag);
        int         lat;
        logic       ok;
        logic [7:0] exp_byte;
        logic [7:0] got;
        ok       = ({24'd0, a} < DEPTH);
        exp_byte = ok ? ref_mem[a[4:0]] : 8'h00;
        got      = 8'h00;
        send_bits({8'h00, a, 1'b0}, 9);
        wait_pulse(1'b1, lat);
        check({tag, " ready latency"}, lat, READ_LAT + 1);
        check({tag, " op_done low at ready"}, bus.op_done, 1'b0);
        ref_err = !ok;
        check({tag, " err"}, bus.err, ref_err);
        for (int i = 0; i < 8; i++) begin
            tick();
            got[i] = bus.miso;
        end
        check({tag, " miso byte"}, got, exp_byte);
        tick();
        check({tag, " miso idle"}, bus.miso, 1'b0);
    endtask

    initial begin
        int         lat;
        int         pulses;
        logic [7:0] a;
        logic [7:0] d;

        bus.cs   = 1'b1;
        bus.mosi = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        check("reset miso", bus.miso, 1'b0);
        check("reset ready", bus.ready, 1'b0);
        check("reset op_done", bus.op_done, 1'b0);
        check("reset err", bus.err, 1'b0);
        rst = 1'b0;
        tick();

        // Give every location a known random value so later scans can detect stray writes
        for (int i = 0; i < DEPTH; i++) begin
            do_write(8'(i), 8'($urandom), "fill");
        end

        // Directed write and read of 0xA5 at address 5
        do_write(8'h05, 8'hA5, "t1 write");
        do_read(8'h05, "t2 read");

        // Out-of-range write sets err and touches nothing; a valid write clears it
        do_write(8'h20, 8'hFF, "t3 oor write");
        scan_mem("t3 scan");
        do_write(8'h01, 8'($urandom), "t3 valid write");

        // Out-of-range read returns zeros and sets err
        do_read(8'h40, "t4 oor read");

        // Abort after 6 bits of a write to address 3
        send_bits({8'h5A, 8'h03, 1'b1}, 6);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.op_done || bus.ready) pulses++;
        end
        check("t5 abort pulses", pulses, 0);
        check("t5 abort err", bus.err, ref_err);
        dbg_addr = 5'd3;
        #1;
        check("t5 abort mem[3]", dbg_data, ref_mem[3]);
        do_write(8'h03, 8'h3C, "t5 write");
        do_read(8'h03, "t5 read");

        // Reset in the middle of a read transmission
        send_bits({8'h00, 8'h05, 1'b0}, 9);
        wait_pulse(1'b1, lat);
        check("t6 ready latency", lat, READ_LAT + 1);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6 rst miso", bus.miso, 1'b0);
        check("t6 rst ready", bus.ready, 1'b0);
        check("t6 rst op_done", bus.op_done, 1'b0);
        check("t6 rst err", bus.err, 1'b0);
        ref_err = 1'b0;
        scan_mem("t6 scan");
        do_write(8'h00, 8'h11, "t6 write0");
        do_write(8'h01, 8'h22, "t6 write1");
        do_read(8'h00, "t6 read0");
        do_read(8'h01, "t6 read1");

        // Randomised mix of reads and writes, some out of range
        for (int n = 0; n < 24; n++) begin
            a = 8'($urandom_range(0, 47));
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) do_write(a, d, $sformatf("rnd%0d write", n));
            else                           do_read(a, $sformatf("rnd%0d read", n));
        end
        scan_mem("final scan");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/spi_peripheral_mem.md
Name: spi_peripheral_mem

Overview:
SPI-style target that sits directly downstream of the team's SPI controller. It consumes that controller's cs/mosi frames and returns ready/op_done/miso.
- Frames are shifted LSB-first, one bit per clk.
- Write frame is 17 bits: {data[7:0], addr[7:0], wr=1}.
- Read frame is 9 bits: {addr[7:0], wr=0}.
- Backing store is a DEPTH x 8 register file. It has a combinational debug read port for scoreboarding.

Parameters:
DEPTH, 32, number of 8-bit storage locations; legal addr range is 0..DEPTH-1.
READ_LAT, 1, idle cycles (>=0) between read-frame end (cs high) and the ready pulse.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
cs  in  1  chip select, active low; frames are bounded by cs low.
mosi  in  1  serial data in, sampled on posedge while cs==0.
miso  out  1  serial read data, LSB first.
ready  out  1  one-cycle pulse: read data starts on miso next cycle.
op_done  out  1  one-cycle pulse: write committed (or discarded).
err  out  1  sticky out-of-range flag; cleared by rst or by the next valid frame.
dbg_addr  in  $clog2(DEPTH)  backdoor read address.
dbg_data  out  8  combinational mem[dbg_addr].

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, bit count=0, shift reg=0, miso=0, ready=0, op_done=0, err=0. Memory contents are NOT cleared. Reset mid-frame or mid-TX aborts immediately with no pulse and no write.
- Bit order: on each posedge with cs==0 in RX, bit[count] is captured from mosi, starting at count=0.
  - bit0 = wr; bits1-8 = addr LSB-first; bits9-16 = data LSB-first.
- States: IDLE, RX, WAIT_CS, WRITE, RD_WAIT, RDY, TX.
- IDLE: when cs==0 at a posedge, capture bit0 on that same edge and go to RX with count=1.
- RX:
  - If wr=0 and count reaches 9, go to RD_WAIT.
  - If wr=1 and count reaches 17, go to WAIT_CS.
  - If cs goes high before the frame completes, abort to IDLE: no write, no pulse, err unchanged.
- WAIT_CS: further bits while cs==0 are ignored. When cs==1, go to WRITE.
- WRITE: one cycle.
  - If addr<DEPTH: mem[addr]<=data, err<=0.
  - Else: memory unchanged, err<=1.
  - op_done=1 on the following cycle for exactly one cycle, then IDLE.
- RD_WAIT: wait for cs==1, then count READ_LAT cycles. Latch rdata = (addr<DEPTH) ? mem[addr] : 8'h00, and set err the same way as a write.
- RDY: ready=1 for exactly one cycle.
- TX: the 8 cycles after the ready pulse present rdata[0]..rdata[7] on miso, registered, one bit per cycle. Then miso=0 and go to IDLE.
  - cs is ignored during RD_WAIT (after cs high), RDY and TX.
  - A cs low during TX is not captured; the next frame starts only from IDLE.
- Latency:
  - Write: cs rise → op_done is 2 cycles.
  - Read: cs rise → ready is READ_LAT+1 cycles; ready → first miso bit is 1 cycle.
- Read-after-write to the same address returns the new data. A write commits before op_done, so any following frame sees it.
- addr is the full 8 bits; an out-of-range address is never truncated or aliased.
- miso=0 whenever not in TX. ready and op_done are never high simultaneously.
- dbg_data reflects writes the cycle after WRITE.

Test Plan:
1. Reset, then write frame wr=1, addr=0x05, data=0xA5 (mosi bits 1,1,0,1,0,0,0,0,0,1,0,1,0,0,1,0,1), then cs high → op_done pulses 2 cycles after cs rise; dbg_addr=5 gives 0xA5; err=0.
2. Read frame wr=0, addr=0x05 (9 bits) → ready pulses READ_LAT+1 cycles after cs rise; miso on the next 8 cycles is 1,0,1,0,0,1,0,1 (=0xA5); miso=0 afterwards.
3. Write addr=0x20 (=DEPTH), data=0xFF → op_done pulses, err=1, no location changed. A following valid write to addr 0x01 clears err to 0.
4. Read addr=0x40 → ready pulse, miso shifts 0x00, err=1.
5. Abort: cs low for 6 bits of a write to addr 0x03, then cs high → no op_done, mem[3] unchanged, state IDLE. The next full write to addr 0x03 with 0x3C succeeds.
6. Assert rst during TX of a read (after bit 3) → miso=0, ready=0 next cycle, mem intact. Back-to-back writes 0x11→addr0 and 0x22→addr1 then both read back correctly.
